// File: rtl/usb_reg_init_pkg.sv
// Shared constants, state encoding and status helper for the register-bus initiator.
package usb_reg_init_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] NAK     = 8'hEE;
   localparam logic [7:0] STS_OK  = 8'h00;
   localparam logic [7:0] STS_ERR = 8'h01;
   localparam logic [7:0] STS_TMO = 8'h02;

   localparam int unsigned RESP_BYTES = 5;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StWdata,
      StBus,
      StResp,
      StNak
   } state_e;

   // err dominates ack; neither means the cycle budget ran out
   function automatic logic [7:0] status_byte(input logic ack, input logic err);
      if (err) return STS_ERR;
      if (ack) return STS_OK;
      return STS_TMO;
   endfunction

endpackage

// File: rtl/usb_reg_resp_ser.sv
// Response serialiser: loads up to five bytes (byte 0 first) and hands them out on valid/ready.
module usb_reg_resp_ser
   import usb_reg_init_pkg::*;
(
   input  logic                      app_clk,
   input  logic                      reset_n,
   input  logic                      i_load,
   input  logic [8*RESP_BYTES-1:0]   i_bytes,
   input  logic [2:0]                i_len,
   output logic [7:0]                o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_last
);

   logic [8*RESP_BYTES-1:0] r_buf;
   logic [2:0]              r_left;

   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_buf  <= '0;
         r_left <= '0;
      end else if (i_load) begin
         r_buf  <= i_bytes;
         r_left <= i_len;
      end else if (o_valid && i_ready) begin
         r_buf  <= {8'h00, r_buf[8*RESP_BYTES-1:8]};
         r_left <= r_left - 3'd1;
      end
   end

   assign o_data  = r_buf[7:0];
   assign o_valid = (r_left != 3'd0);
   assign o_last  = o_valid && i_ready && (r_left == 3'd1);

endmodule

// File: rtl/usb_reg_initiator.sv
// Byte-stream command parser that issues one register-bus transaction per frame and
// streams back a status byte (plus read data for reads).
module usb_reg_initiator
   import usb_reg_init_pkg::*;
#(
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic              app_clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              reg_cs,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic [3:0]        reg_be,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_ack,
   input  logic              reg_err,
   output logic              busy
);

   // Completing on count 2**W-2 keeps reg_cs high for exactly 2**W-1 cycles.
   localparam logic [TIMEOUT_W-1:0] TmoLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_e                  r_state, w_state_d;
   logic [1:0]              r_cnt;
   logic                    r_is_wr;
   logic [ADDR_W-1:0]       r_addr;
   logic [31:0]             r_wdata;
   logic [3:0]              r_be;
   logic                    r_rx_ready;
   logic [TIMEOUT_W-1:0]    r_tmo;

   logic                    w_rx_fire;
   logic                    w_tmo_hit;
   logic [7:0]              w_sts;
   logic [31:0]             w_rdata;
   logic                    w_ser_load;
   logic [2:0]              w_ser_len;
   logic [8*RESP_BYTES-1:0] w_ser_bytes;
   logic                    w_ser_last;
   logic                    w_unused;

   assign w_rx_fire = rx_valid && r_rx_ready;
   assign w_tmo_hit = (r_tmo == TmoLast);
   assign w_sts     = status_byte(reg_ack, reg_err);
   assign w_rdata   = (reg_ack && !reg_err) ? reg_rdata : 32'h0;
   assign w_unused  = rx_data[3];

   always_comb begin
      w_state_d   = r_state;
      w_ser_load  = 1'b0;
      w_ser_len   = 3'd0;
      w_ser_bytes = '0;
      unique case (r_state)
         StIdle: begin
            if (w_rx_fire) begin
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  w_state_d = StHdr;
               end else begin
                  w_state_d   = StNak;
                  w_ser_load  = 1'b1;
                  w_ser_len   = 3'd1;
                  w_ser_bytes = {32'h0, NAK};
               end
            end
         end
         StHdr: begin
            if (w_rx_fire && r_cnt == 2'd1) w_state_d = r_is_wr ? StWdata : StBus;
         end
         StWdata: begin
            if (w_rx_fire && r_cnt == 2'd3) w_state_d = StBus;
         end
         StBus: begin
            if (reg_ack || reg_err || w_tmo_hit) begin
               w_state_d   = StResp;
               w_ser_load  = 1'b1;
               w_ser_len   = r_is_wr ? 3'd1 : 3'd5;
               w_ser_bytes = {w_rdata, w_sts};
            end
         end
         StResp, StNak: begin
            if (w_ser_last) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_rx_ready <= 1'b0;
         r_cnt      <= 2'd0;
         r_tmo      <= '0;
      end else begin
         r_state    <= w_state_d;
         r_rx_ready <= (w_state_d == StIdle) || (w_state_d == StHdr) || (w_state_d == StWdata);
         if (r_state != w_state_d) r_cnt <= 2'd0;
         else if (w_rx_fire)       r_cnt <= r_cnt + 2'd1;
         if (r_state != StBus)     r_tmo <= '0;
         else if (r_tmo != '1)     r_tmo <= r_tmo + 1'b1;
      end
   end

   // Request fields only move while a frame is being received, so they are stable under reg_cs.
   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_is_wr <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_rx_fire) begin
         case (r_state)
            StIdle:  r_is_wr <= (rx_data == CMD_WR);
            StHdr: begin
               if (r_cnt == 2'd0) begin
                  r_be               <= rx_data[7:4];
                  r_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
               end else begin
                  r_addr[7:0] <= rx_data;
               end
            end
            StWdata: r_wdata <= {rx_data, r_wdata[31:8]};
            default: ;
         endcase
      end
   end

   usb_reg_resp_ser u_resp_ser (
      .app_clk (app_clk),
      .reset_n (reset_n),
      .i_load  (w_ser_load),
      .i_bytes (w_ser_bytes),
      .i_len   (w_ser_len),
      .o_data  (tx_data),
      .o_valid (tx_valid),
      .i_ready (tx_ready),
      .o_last  (w_ser_last)
   );

   assign rx_ready  = r_rx_ready;
   assign reg_cs    = (r_state == StBus);
   assign reg_wr    = r_is_wr;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_be    = r_be;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_usb_reg_initiator.sv
// Randomised self-checking bench: frames in, register responder and tx sink modelled in the bench.
module tb_usb_reg_initiator;

   logic        app_clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        reg_cs;
   logic        reg_wr;
   logic [10:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata = 32'h0;
   logic        reg_ack = 1'b0;
   logic        reg_err = 1'b0;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   // Transaction plan shared with the responder; mode 0 ack, 1 err, 2 silent, 3 ack+err.
   logic        p_wr = 1'b0;
   logic [10:0] p_addr = '0;
   logic [3:0]  p_be = '0;
   logic [31:0] p_wdata = '0;
   logic [31:0] p_rdata = '0;
   int          p_mode = 0;
   int          p_dly = 1;
   int          p_cs_len = 1;
   int          cs_cnt = 0;
   int          cs_txns = 0;

   logic [7:0]  got[$];
   int          stall_after = -1;
   int          stall_cnt = 0;
   logic        hold = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   always #5 app_clk = ~app_clk;

   usb_reg_initiator #(
      .ADDR_W    (11),
      .TIMEOUT_W (8)
   ) dut (
      .app_clk   (app_clk),
      .reset_n   (reset_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .reg_cs    (reg_cs),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_be    (reg_be),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack),
      .reg_err   (reg_err),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Register responder: answers on the p_dly-th reg_cs cycle, injects noise when idle.
   always @(negedge app_clk) begin
      if (!reset_n) begin
         cs_cnt  = 0;
         reg_ack = 1'b0;
         reg_err = 1'b0;
      end else if (reg_cs) begin
         cs_cnt++;
         if (cs_cnt == 1) cs_txns++;
         chk("reg_wr", 32'(reg_wr), 32'(p_wr));
         chk("reg_addr", 32'(reg_addr), 32'(p_addr));
         chk("reg_be", 32'(reg_be), 32'(p_be));
         if (p_wr) chk("reg_wdata", reg_wdata, p_wdata);
         chk("tx_valid_in_bus", 32'(tx_valid), 32'd0);
         if (p_mode != 2 && cs_cnt == p_dly) begin
            reg_ack   = (p_mode == 0 || p_mode == 3);
            reg_err   = (p_mode == 1 || p_mode == 3);
            reg_rdata = p_rdata;
         end else begin
            reg_ack   = 1'b0;
            reg_err   = 1'b0;
            reg_rdata = $urandom;
         end
      end else begin
         if (cs_cnt > 0) chk("cs_len", 32'(cs_cnt), 32'(p_cs_len));
         cs_cnt    = 0;
         reg_ack   = ($urandom_range(0, 3) == 0);
         reg_err   = ($urandom_range(0, 3) == 0);
         reg_rdata = $urandom;
      end
   end

   // Response sink: random backpressure, optional 10-cycle stall, hold/backpressure checks.
   always @(negedge app_clk) begin
      logic rdy;
      if (!reset_n) begin
         tx_ready = 1'b0;
         hold     = 1'b0;
      end else begin
         if (hold) begin
            chk("tx_hold_valid", 32'(tx_valid), 32'd1);
            chk("tx_hold_data", 32'(tx_data), 32'(hold_data));
         end
         if (tx_valid) chk("rx_ready_in_resp", 32'(rx_ready), 32'd0);
         if (stall_after >= 0 && got.size() == stall_after && tx_valid) begin
            stall_cnt   = 10;
            stall_after = -1;
         end
         if (stall_cnt > 0) begin
            rdy = 1'b0;
            stall_cnt--;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         tx_ready = rdy;
         if (tx_valid && rdy) got.push_back(tx_data);
         hold      = tx_valid && !rdy;
         hold_data = tx_data;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      repeat ($urandom_range(0, 2)) @(negedge app_clk);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 2000) begin
         @(negedge app_clk);
         n++;
      end
      chk("rx_accept", 32'(rx_ready), 32'd1);
      @(negedge app_clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   // kind: 0 write, 1 read, 2 unknown command byte bad_cmd.
   task automatic run_txn(input int kind, input logic [7:0] bad_cmd, input logic [10:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata, input int mode,
                          input int dly, input logic [31:0] rdata);
      logic [7:0]  frame[$];
      logic [7:0]  exp_q[$];
      logic [7:0]  sts;
      logic [31:0] rd;
      int          base_txns;
      int          n;
      p_wr     = (kind == 0);
      p_addr   = addr;
      p_be     = be;
      p_wdata  = wdata;
      p_rdata  = rdata;
      p_mode   = mode;
      p_dly    = dly;
      p_cs_len = (mode == 2) ? 255 : dly;
      base_txns = cs_txns;
      if (kind == 2) begin
         frame.push_back(bad_cmd);
         exp_q.push_back(8'hEE);
      end else begin
         frame.push_back((kind == 0) ? 8'h57 : 8'h52);
         frame.push_back({be, 1'b0, addr[10:8]});
         frame.push_back(addr[7:0]);
         if (kind == 0) for (int i = 0; i < 4; i++) frame.push_back(wdata[8*i +: 8]);
         sts = (mode == 2) ? 8'h02 : ((mode == 0) ? 8'h00 : 8'h01);
         rd  = (mode == 0) ? rdata : 32'h0;
         exp_q.push_back(sts);
         if (kind == 1) for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
      end
      foreach (frame[i]) send_byte(frame[i]);
      n = 0;
      while (got.size() < exp_q.size() && n < 3000) begin
         @(negedge app_clk);
         n++;
      end
      n = 0;
      while (busy && n < 100) begin
         @(negedge app_clk);
         n++;
      end
      chk("busy_idle", 32'(busy), 32'd0);
      chk("tx_count", 32'(got.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) if (i < got.size()) chk("tx_byte", 32'(got[i]), 32'(exp_q[i]));
      chk("cs_txns", 32'(cs_txns - base_txns), (kind == 2) ? 32'd0 : 32'd1);
      got.delete();
   endtask

   initial begin
      int n;
      int kind;
      int mode;
      logic [7:0] bad;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_reg_cs", 32'(reg_cs), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_reg_wr", 32'(reg_wr), 32'd0);
      repeat (3) @(negedge app_clk);
      #2 reset_n = 1'b1;
      @(negedge app_clk);
      chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

      run_txn(0, 8'h00, 11'h024, 4'hF, 32'h44332211, 0, 3, 32'h0);
      run_txn(1, 8'h00, 11'h310, 4'hF, 32'h0, 0, 1, 32'hDEADBEEF);
      run_txn(1, 8'h00, 11'h155, 4'h3, 32'h0, 2, 1, 32'h0);
      run_txn(0, 8'h00, 11'h7FF, 4'h1, 32'hCAFEF00D, 1, 2, 32'h0);
      run_txn(2, 8'h41, 11'h0, 4'h0, 32'h0, 0, 1, 32'h0);
      run_txn(1, 8'h00, 11'h0AB, 4'hC, 32'h0, 3, 2, 32'h12345678);
      stall_after = 2;
      run_txn(1, 8'h00, 11'h400, 4'hF, 32'h0, 0, 4, 32'hA5B6C7D8);
      stall_after = -1;

      // Reset while a read sits in BUS waiting for a response that never comes.
      p_wr = 1'b0; p_addr = 11'h310; p_be = 4'hF; p_mode = 2; p_cs_len = 255;
      send_byte(8'h52);
      send_byte(8'hF3);
      send_byte(8'h10);
      n = 0;
      while (!reg_cs && n < 50) begin
         @(negedge app_clk);
         n++;
      end
      chk("cs_before_abort", 32'(reg_cs), 32'd1);
      repeat (5) @(negedge app_clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_reg_cs", 32'(reg_cs), 32'd0);
      chk("abort_tx_valid", 32'(tx_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge app_clk);
      #2 reset_n = 1'b1;
      got.delete();
      @(negedge app_clk);
      chk("rx_ready_after_abort", 32'(rx_ready), 32'd1);
      run_txn(0, 8'h00, 11'h123, 4'h6, 32'h0BADF00D, 0, 2, 32'h0);

      for (int t = 0; t < 40; t++) begin
         kind = ($urandom_range(0, 6) < 3) ? 0 : 1;
         if ($urandom_range(0, 6) == 0) kind = 2;
         mode = $urandom_range(0, 9);
         mode = (mode < 6) ? 0 : ((mode < 8) ? 1 : ((mode == 8) ? 3 : 2));
         if ($urandom_range(0, 3) != 0 && mode == 2) mode = 0;
         bad = 8'($urandom);
         if (bad == 8'h57 || bad == 8'h52) bad = 8'h00;
         run_txn(kind, bad, 11'($urandom), 4'($urandom), $urandom, mode,
                 $urandom_range(1, 8), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
